// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU codes, immediate-extension selects and the decoded-entry layout
package cpu_pkg;
    localparam logic [6:0] OP_RTYPE  = 7'h00;
    localparam logic [6:0] OP_SHIFTI = 7'h01;
    localparam logic [6:0] OP_ADDI   = 7'h08;
    localparam logic [6:0] OP_ORI    = 7'h0C;
    localparam logic [6:0] OP_XORI   = 7'h0D;
    localparam logic [6:0] OP_ANDI   = 7'h0E;
    localparam logic [6:0] OP_MOVI   = 7'h20;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_AND   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_XOR   = 4'h4;
    localparam logic [3:0] ALU_PASSB = 4'hF;

    typedef enum logic [1:0] {IMM_5 = 2'd0, IMM_15 = 2'd1, IMM_20 = 2'd2} ext_sel_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [3:0]  alu_op;
        logic        use_imm;
        logic        sign_ena;
        ext_sel_t    ext_sel;
        logic [19:0] imm_field;
        logic        illegal;
    } decoded_t;
endpackage

// File: rtl/id_decode_stage_if.sv
// id_decode_stage_if: fetch-side and execute-side handshake of the decode stage
interface id_decode_stage_if;
    import cpu_pkg::*;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [3:0]  alu_op;
    logic        use_imm;
    logic        sign_ena;
    ext_sel_t    ext_sel;
    logic [19:0] imm_field;
    logic        illegal;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, rd, rs, rt, alu_op, use_imm, sign_ena, ext_sel, imm_field, illegal
    );
    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, rd, rs, rt, alu_op, use_imm, sign_ena, ext_sel, imm_field, illegal
    );
endinterface

// File: rtl/id_decoder.sv
// id_decoder: combinational instruction decode into a decoded_t entry
module id_decoder
    import cpu_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output decoded_t    o_dec
);
    logic [6:0] w_op;
    assign w_op = i_instr[31:25];

    always_comb begin
        o_dec           = '0;
        o_dec.pc        = i_pc;
        o_dec.rd        = i_instr[24:20];
        o_dec.rs        = i_instr[19:15];
        o_dec.rt        = i_instr[14:10];
        o_dec.imm_field = i_instr[19:0];
        o_dec.use_imm   = 1'b1;
        case (w_op)
            OP_RTYPE: begin
                o_dec.alu_op  = i_instr[3:0];
                o_dec.use_imm = 1'b0;
            end
            OP_SHIFTI: o_dec.alu_op = i_instr[3:0];
            OP_ADDI: begin
                o_dec.alu_op   = ALU_ADD;
                o_dec.ext_sel  = IMM_15;
                o_dec.sign_ena = 1'b1;
            end
            OP_ORI: begin
                o_dec.alu_op  = ALU_OR;
                o_dec.ext_sel = IMM_15;
            end
            OP_XORI: begin
                o_dec.alu_op  = ALU_XOR;
                o_dec.ext_sel = IMM_15;
            end
            OP_ANDI: begin
                o_dec.alu_op  = ALU_AND;
                o_dec.ext_sel = IMM_15;
            end
            OP_MOVI: begin
                o_dec.alu_op   = ALU_PASSB;
                o_dec.ext_sel  = IMM_20;
                o_dec.sign_ena = 1'b1;
            end
            default: begin
                o_dec.illegal = 1'b1;
                o_dec.use_imm = 1'b0;
                o_dec.ext_sel = IMM_20;
            end
        endcase
    end
endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: decode on accept into a 2-entry skid buffer; in_ready depends only on registered state
module id_decode_stage
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    id_decode_stage_if.slave  bus
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t   r_state, w_next;
    logic     r_head;
    decoded_t r_entry [DEPTH];
    decoded_t w_dec;
    decoded_t w_head;
    logic     w_accept, w_pop, w_tail;

    id_decoder u_dec (.i_instr(bus.in_instr), .i_pc(bus.in_pc), .o_dec(w_dec));

    assign w_accept = bus.in_valid & (r_state != FULL);
    assign w_pop    = bus.out_ready & (r_state != EMPTY);
    // The free slot sits at head when empty, otherwise just past it.
    assign w_tail   = r_head ^ (r_state != EMPTY);
    assign w_head   = r_entry[r_head];

    always_comb begin
        w_next = r_state;
        if (bus.flush)
            w_next = EMPTY;
        else
            case (r_state)
                EMPTY: w_next = w_accept ? ONE : EMPTY;
                ONE: w_next = (w_accept && !w_pop) ? FULL : (!w_accept && w_pop) ? EMPTY : ONE;
                FULL: w_next = w_pop ? ONE : FULL;
                default: w_next = EMPTY;
            endcase
        bus.in_ready  = r_state != FULL;
        bus.out_valid = r_state != EMPTY;
        bus.out_pc    = w_head.pc;
        bus.rd        = w_head.rd;
        bus.rs        = w_head.rs;
        bus.rt        = w_head.rt;
        bus.alu_op    = w_head.alu_op;
        bus.use_imm   = w_head.use_imm;
        bus.sign_ena  = w_head.sign_ena;
        bus.ext_sel   = w_head.ext_sel;
        bus.imm_field = w_head.imm_field;
        bus.illegal   = w_head.illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_head  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
        end else begin
            r_state <= w_next;
            if (w_pop) r_head <= ~r_head;
            if (w_accept && !bus.flush) r_entry[w_tail] <= w_dec;
        end
    end
endmodule
